vga_lcd_prefetch: RTL and testbench

//  Read-only Wishbone master that drives the LCD port of the VGA memory arbiter.

---
 rtl/vga_lcd_prefetch.sv | 145 ++++++++++++++
 tb/tb_vga_lcd_prefetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_lcd_prefetch.sv
// LCD-port prefetcher: walks one frame as a Wishbone read master, one request
// outstanding at a time, and buffers the fetched words in a small pixel FIFO.
module vga_lcd_prefetch #(
  parameter int fml_depth  = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 frame_start_i,
  input  logic [fml_depth-2:0] base_adr_i,
  input  logic [11:0]          words_per_line_i,
  input  logic [11:0]          line_stride_i,
  input  logic [10:0]          num_lines_i,
  output logic                 busy_o,
  output logic                 underflow_o,
  output logic [fml_depth-2:0] lcd_adr_o,
  output logic [1:0]           lcd_sel_o,
  output logic                 lcd_cyc_o,
  output logic                 lcd_stb_o,
  input  logic [15:0]          lcd_dat_i,
  input  logic                 lcd_ack_i,
  output logic [15:0]          pix_dat_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i
);

  localparam int AW = fml_depth - 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_REQ,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   words_q, stride_q, word_cnt_q;
  logic [10:0]   lines_q, line_cnt_q;
  logic [AW-1:0] line_base_q;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          empty, has_room, push, pop;
  logic          last_word, last_line, cfg_empty;

  assign empty     = (count_q == '0);
  assign has_room  = (count_q <= (PW+1)'(FIFO_DEPTH - 1));
  assign last_word = (word_cnt_q == words_q - 12'd1);
  assign last_line = (line_cnt_q == lines_q - 11'd1);
  assign cfg_empty = (words_per_line_i == '0) || (num_lines_i == '0);

  // frame_start_i kills the strobe combinationally so an abort drops stb in
  // the same cycle; an ack arriving in that cycle is then never accepted.
  assign push = (state_q == S_REQ) && lcd_ack_i && !frame_start_i;
  assign pop  = !empty && pix_ready_i && !frame_start_i;

  assign busy_o      = (state_q != S_IDLE);
  assign lcd_stb_o   = (state_q == S_REQ) && !frame_start_i;
  assign lcd_cyc_o   = lcd_stb_o;
  assign lcd_sel_o   = {2{lcd_stb_o}};
  assign lcd_adr_o   = line_base_q + AW'(word_cnt_q);
  assign pix_valid_o = !empty;
  assign pix_dat_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = cfg_empty ? S_IDLE : S_ISSUE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ISSUE: if (has_room) state_d = S_REQ;
        S_REQ:   if (lcd_ack_i) state_d = S_GAP;
        S_GAP:   state_d = (last_word && last_line) ? S_DRAIN : S_ISSUE;
        S_DRAIN: if (empty) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shadow configuration and frame walk counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      words_q     <= '0;
      stride_q    <= '0;
      lines_q     <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      line_base_q <= '0;
    end else if (frame_start_i) begin
      words_q     <= words_per_line_i;
      stride_q    <= line_stride_i;
      lines_q     <= num_lines_i;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      line_base_q <= base_adr_i;
    end else if (state_q == S_GAP) begin
      if (!last_word) begin
        word_cnt_q <= word_cnt_q + 12'd1;
      end else if (!last_line) begin
        word_cnt_q  <= '0;
        line_cnt_q  <= line_cnt_q + 11'd1;
        line_base_q <= line_base_q + AW'(stride_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (frame_start_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= lcd_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 underflow_o <= 1'b0;
    else if (frame_start_i)                    underflow_o <= 1'b0;
    else if (busy_o && pix_ready_i && empty)   underflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_vga_lcd_prefetch.sv
// Randomized bench for vga_lcd_prefetch: a Wishbone slave with random latency
// and repeated acks, a random-ready consumer, and a frame address/data model.
module tb_vga_lcd_prefetch;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          frame_start_i;
  logic [AW-1:0] base_adr_i;
  logic [11:0]   words_per_line_i, line_stride_i;
  logic [10:0]   num_lines_i;
  logic          busy_o, underflow_o, lcd_cyc_o, lcd_stb_o, lcd_ack_i;
  logic [AW-1:0] lcd_adr_o;
  logic [1:0]    lcd_sel_o;
  logic [15:0]   lcd_dat_i, pix_dat_o;
  logic          pix_valid_o, pix_ready_i;

  always #5 clk = ~clk;

  vga_lcd_prefetch #(.fml_depth(20), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .base_adr_i(base_adr_i), .words_per_line_i(words_per_line_i),
    .line_stride_i(line_stride_i), .num_lines_i(num_lines_i),
    .busy_o(busy_o), .underflow_o(underflow_o), .lcd_adr_o(lcd_adr_o),
    .lcd_sel_o(lcd_sel_o), .lcd_cyc_o(lcd_cyc_o), .lcd_stb_o(lcd_stb_o),
    .lcd_dat_i(lcd_dat_i), .lcd_ack_i(lcd_ack_i), .pix_dat_o(pix_dat_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the expected request addresses and pixel words of a frame.
  logic [AW-1:0] exp_adr_q[$];
  logic [15:0]   exp_pix_q[$];
  int            planned, nreq, npop;
  int            ready_pct, fixed_delay, wait_left;
  bit            req_seen, dup_pending, dup_en, uf_model;
  logic [AW-1:0] held_adr;

  function automatic logic [15:0] data_of(input logic [AW-1:0] a);
    logic [31:0] t;
    t = ({13'd0, a} * 32'd3) ^ ({13'd0, a} >> 7) ^ 32'h5A3C;
    return t[15:0];
  endfunction

  task automatic plan_frame(input logic [AW-1:0] base, input int words, input int stride,
                            input int lines);
    logic [31:0] s;
    exp_adr_q.delete();
    exp_pix_q.delete();
    for (int l = 0; l < lines; l++)
      for (int w = 0; w < words; w++) begin
        s = {13'd0, base} + 32'(l * stride) + 32'(w);
        exp_adr_q.push_back(s[AW-1:0]);
        exp_pix_q.push_back(data_of(s[AW-1:0]));
      end
    planned = words * lines;
  endtask

  task automatic step();
    check_val("underflow", underflow_o, uf_model);
    if (lcd_stb_o && !req_seen) begin
      req_seen = 1;
      nreq++;
      held_adr = lcd_adr_o;
      check_val("req_sel", lcd_sel_o, 3);
      check_val("req_cyc", lcd_cyc_o, 1);
      if (exp_adr_q.size() != 0) check_val("req_adr", lcd_adr_o, exp_adr_q.pop_front());
      wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
    end else if (lcd_stb_o) begin
      check_val("adr_stable", lcd_adr_o, held_adr);
    end
    lcd_ack_i = 1'b0;
    if (dup_pending) begin
      lcd_ack_i   = 1'b1;
      dup_pending = 0;
    end else if (lcd_stb_o) begin
      if (wait_left == 0) begin
        lcd_ack_i   = 1'b1;
        lcd_dat_i   = data_of(lcd_adr_o);
        req_seen    = 0;
        dup_pending = dup_en && ($urandom_range(1) == 1);
      end else begin
        wait_left--;
      end
    end
    pix_ready_i = ($urandom_range(99) < ready_pct);
    if (pix_valid_o && pix_ready_i) begin
      npop++;
      if (exp_pix_q.size() != 0) check_val("pix_dat", pix_dat_o, exp_pix_q.pop_front());
    end
    if (busy_o && pix_ready_i && !pix_valid_o) uf_model = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int words, input int stride,
                             input int lines);
    plan_frame(base, words, stride, lines);
    frame_start_i    = 1'b1;
    base_adr_i       = base;
    words_per_line_i = 12'(words);
    line_stride_i    = 12'(stride);
    num_lines_i      = 11'(lines);
    lcd_ack_i        = 1'b0;
    pix_ready_i      = 1'b0;
    #1;
    check_val("stb_on_start", lcd_stb_o, 0);
    @(posedge clk);
    #1;
    frame_start_i    = 1'b0;
    base_adr_i       = AW'($urandom);
    words_per_line_i = 12'($urandom);
    line_stride_i    = 12'($urandom);
    num_lines_i      = 11'($urandom);
    nreq = 0; npop = 0; req_seen = 0; dup_pending = 0; uf_model = 0;
    check_val("valid_after_start", pix_valid_o, 0);
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_idle"}, busy_o, 0);
    check_val({tag, "_reqs"}, nreq, planned);
    check_val({tag, "_pops"}, npop, planned);
    check_val({tag, "_valid"}, pix_valid_o, 0);
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!lcd_stb_o && n < 50) begin
      step();
      n++;
    end
    check_val(tag, lcd_stb_o, 1);
  endtask

  initial begin
    rst_i = 1'b1; frame_start_i = 1'b0; base_adr_i = '0; words_per_line_i = '0;
    line_stride_i = '0; num_lines_i = '0; lcd_ack_i = 1'b0; lcd_dat_i = '0;
    pix_ready_i = 1'b0;
    ready_pct = 100; fixed_delay = 1; dup_en = 0; uf_model = 0;
    nreq = 0; npop = 0; planned = 0; req_seen = 0; dup_pending = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs",
              {busy_o, underflow_o, lcd_cyc_o, lcd_stb_o, lcd_sel_o, pix_valid_o},
              0);
    check_val("rst_adr", lcd_adr_o, 0);
    check_val("rst_pix", pix_dat_o, 0);
    rst_i = 1'b0;

    // Basic two-line frame with a one-cycle slave and an always-ready consumer.
    start_frame(19'h100, 4, 8, 2);
    run_to_idle("basic", 200);

    // Slave repeats its ack in the gap cycle.
    dup_en = 1; fixed_delay = 0;
    start_frame(19'h040, 5, 16, 2);
    dup_en = 1;
    run_to_idle("dup_ack", 300);

    // Stalled consumer: FIFO fills to exactly its depth, then drains in order.
    dup_en = 0; fixed_delay = -1; ready_pct = 0;
    start_frame(19'h1234, 40, 40, 1);
    repeat (150) step();
    check_val("stall_reqs", nreq, 16);
    check_val("stall_stb", lcd_stb_o, 0);
    check_val("stall_valid", pix_valid_o, 1);
    ready_pct = 100;
    run_to_idle("stall", 1000);

    // Abort in the middle of a request.
    start_frame(19'h300, 8, 8, 2);
    wait_stb("abort_stb_seen");
    start_frame(19'h200, 4, 4, 1);
    run_to_idle("abort", 200);

    // Address wrap at the top of the word address space.
    start_frame(19'h7FFFF, 2, 0, 1);
    run_to_idle("wrap", 100);

    // Slow slave with a ready consumer: sticky underflow, cleared by a new frame.
    fixed_delay = 10;
    start_frame(19'h500, 2, 2, 1);
    run_to_idle("slow", 200);
    check_val("uf_set", underflow_o, 1);
    repeat (5) step();
    check_val("uf_sticky", underflow_o, 1);
    start_frame(19'h0, 0, 3, 4);
    repeat (5) step();
    check_val("empty_w_busy", busy_o, 0);
    check_val("uf_cleared", underflow_o, 0);
    start_frame(19'h0, 5, 3, 0);
    repeat (5) step();
    check_val("empty_l_busy", busy_o, 0);
    check_val("empty_l_reqs", nreq, 0);

    // Randomized frames, some aborted part way through.
    for (int f = 0; f < 14; f++) begin
      fixed_delay = -1;
      ready_pct   = int'($urandom_range(100, 20));
      start_frame(AW'($urandom), int'($urandom_range(12, 1)), int'($urandom_range(4095)),
                  int'($urandom_range(4, 1)));
      dup_en = ($urandom_range(1) == 1);
      if ($urandom_range(3) == 0) repeat (int'($urandom_range(40, 5))) step();
      else run_to_idle("rand", 3000);
    end
    run_to_idle("rand_last", 3000);

    // Asynchronous reset during a request.
    fixed_delay = 5; dup_en = 0;
    start_frame(19'h0ABC, 6, 6, 2);
    wait_stb("rst_stb_seen");
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check_val("arst_stb", {lcd_cyc_o, lcd_stb_o}, 0);
    check_val("arst_valid", pix_valid_o, 0);
    check_val("arst_busy", busy_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_adr_q.delete(); exp_pix_q.delete();
    uf_model = 0; req_seen = 0; dup_pending = 0; lcd_ack_i = 1'b0;
    repeat (4) step();
    check_val("arst_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
